// File: rtl/tbus_arbiter.sv
// Two-requester arbiter (IF fetch, LS mem stage) for a single tbus channel to memory.
// Optional perf counters are compiled in when TBUS_ARB_PERF_EN is defined.
module tbus_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned MASK_W       = 64,
  parameter int unsigned TYPE_W       = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_index_valid,
  output logic              if_index_ready,
  input  logic [ADDR_W-1:0] if_index,
  input  logic [TYPE_W-1:0] if_operation_type,
  output logic [DATA_W-1:0] if_read_data,
  output logic              if_operation_done,
  input  logic              ls_index_valid,
  output logic              ls_index_ready,
  input  logic [ADDR_W-1:0] ls_index,
  input  logic [DATA_W-1:0] ls_write_data,
  input  logic [MASK_W-1:0] ls_write_mask,
  input  logic [TYPE_W-1:0] ls_operation_type,
  output logic [DATA_W-1:0] ls_read_data,
  output logic              ls_operation_done,
  output logic              tbus_index_valid,
  input  logic              tbus_index_ready,
  output logic [ADDR_W-1:0] tbus_index,
  output logic [DATA_W-1:0] tbus_write_data,
  output logic [MASK_W-1:0] tbus_write_mask,
  output logic [TYPE_W-1:0] tbus_operation_type,
  input  logic [DATA_W-1:0] tbus_read_data,
  input  logic              tbus_operation_done
`ifdef TBUS_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_ls_grants,
  output logic [31:0]       perf_busy_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_e;

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             grant_if, grant_ls, fire;

  // Grant selection, request mux, done routing and next state
  always_comb begin
    state_d             = state_q;
    owner_d             = owner_q;
    starve_d            = starve_q;
    grant_if            = 1'b0;
    grant_ls            = 1'b0;
    fire                = 1'b0;
    tbus_index_valid    = 1'b0;
    tbus_index          = '0;
    tbus_write_data     = '0;
    tbus_write_mask     = '0;
    tbus_operation_type = '0;
    if_index_ready      = 1'b0;
    ls_index_ready      = 1'b0;
    if_operation_done   = 1'b0;
    ls_operation_done   = 1'b0;
    if_read_data        = '0;
    ls_read_data        = '0;

    case (state_q)
      ST_IDLE: begin
        grant_ls = ls_index_valid && !(if_index_valid && (starve_q == STARVE_MAX));
        grant_if = if_index_valid && !grant_ls;
      end
      ST_REQ: begin
        grant_if = (owner_q == OWN_IF) && if_index_valid;
        grant_ls = (owner_q == OWN_LS) && ls_index_valid;
      end
      default: ;
    endcase

    if (grant_ls) begin
      tbus_index_valid    = 1'b1;
      tbus_index          = ls_index;
      tbus_write_data     = ls_write_data;
      tbus_write_mask     = ls_write_mask;
      tbus_operation_type = ls_operation_type;
    end else if (grant_if) begin
      tbus_index_valid    = 1'b1;
      tbus_index          = if_index;
      tbus_operation_type = if_operation_type;
    end

    fire           = tbus_index_valid && tbus_index_ready;
    if_index_ready = grant_if && tbus_index_ready;
    ls_index_ready = grant_ls && tbus_index_ready;

    case (state_q)
      ST_IDLE, ST_REQ: begin
        if (grant_if || grant_ls) begin
          owner_d = grant_ls ? OWN_LS : OWN_IF;
          if (fire && tbus_operation_done) begin
            if_operation_done = grant_if;
            ls_operation_done = grant_ls;
            state_d           = ST_IDLE;
            owner_d           = OWN_NONE;
          end else if (fire) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      ST_WAIT: begin
        if (tbus_operation_done) begin
          if_operation_done = (owner_q == OWN_IF);
          ls_operation_done = (owner_q == OWN_LS);
          state_d           = ST_IDLE;
          owner_d           = OWN_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    if (if_operation_done) if_read_data = tbus_read_data;
    if (ls_operation_done) ls_read_data = tbus_read_data;

    // LS overtaking a waiting IF counts toward forcing an IF grant
    if (fire && grant_ls) begin
      if (!if_index_valid)              starve_d = '0;
      else if (starve_q != STARVE_MAX)  starve_d = CNT_W'(starve_q + 1'b1);
    end else if (fire && grant_if) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

`ifdef TBUS_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_if_grants   <= '0;
      perf_ls_grants   <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (fire && grant_if)    perf_if_grants   <= perf_if_grants + 32'd1;
      if (fire && grant_ls)    perf_ls_grants   <= perf_ls_grants + 32'd1;
      if (state_q != ST_IDLE)  perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tbus_arbiter.sv
// Scoreboard bench for tbus_arbiter: expected grants/dones are queued as requests are issued
// and checked as the arbiter fires requests and routes completions.
module tb_tbus_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_index_valid, if_index_ready, if_operation_done;
  logic [63:0] if_index, if_read_data;
  logic [1:0]  if_operation_type;
  logic        ls_index_valid, ls_index_ready, ls_operation_done;
  logic [63:0] ls_index, ls_write_data, ls_write_mask, ls_read_data;
  logic [1:0]  ls_operation_type;
  logic        tbus_index_valid, tbus_index_ready, tbus_operation_done;
  logic [63:0] tbus_index, tbus_write_data, tbus_write_mask, tbus_read_data;
  logic [1:0]  tbus_operation_type;
`ifdef TBUS_ARB_PERF_EN
  logic [31:0] perf_if_grants, perf_ls_grants, perf_busy_cycles;
`endif

  tbus_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .if_index_valid(if_index_valid), .if_index_ready(if_index_ready), .if_index(if_index),
    .if_operation_type(if_operation_type), .if_read_data(if_read_data),
    .if_operation_done(if_operation_done),
    .ls_index_valid(ls_index_valid), .ls_index_ready(ls_index_ready), .ls_index(ls_index),
    .ls_write_data(ls_write_data), .ls_write_mask(ls_write_mask),
    .ls_operation_type(ls_operation_type), .ls_read_data(ls_read_data),
    .ls_operation_done(ls_operation_done),
    .tbus_index_valid(tbus_index_valid), .tbus_index_ready(tbus_index_ready),
    .tbus_index(tbus_index), .tbus_write_data(tbus_write_data),
    .tbus_write_mask(tbus_write_mask), .tbus_operation_type(tbus_operation_type),
    .tbus_read_data(tbus_read_data), .tbus_operation_done(tbus_operation_done)
`ifdef TBUS_ARB_PERF_EN
    , .perf_if_grants(perf_if_grants), .perf_ls_grants(perf_ls_grants),
    .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        ls;
    logic [63:0] idx;
    logic [63:0] wd;
    logic [63:0] wm;
    logic [1:0]  ty;
  } req_t;

  typedef struct packed {
    logic        ls;
    logic [63:0] data;
  } done_t;

  req_t  if_q[$], ls_q[$], exp_grant_q[$];
  done_t exp_done_q[$];

  int n_cmp = 0, n_err = 0;
  int n_if_done = 0, n_ls_done = 0;
  int ready_delay = 0, done_delay = 1;
  bit resp_en = 1'b1;
  logic man_ready = 1'b0, man_done = 1'b0;
  logic [63:0] man_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [63:0] idx);
    return (idx * 64'd7) ^ 64'hC0DE_0000_FACE_0000;
  endfunction

  task automatic req(input logic ls, input logic [63:0] idx, input logic [63:0] wd,
                     input logic [63:0] wm, input logic [1:0] ty);
    req_t r;
    r = '{ls: ls, idx: idx, wd: wd, wm: wm, ty: ty};
    if (ls) ls_q.push_back(r);
    else    if_q.push_back(r);
  endtask

  // Expected grant order is pushed explicitly; IF grants must carry zero data and mask
  task automatic expect_txn(input logic ls, input logic [63:0] idx, input logic [63:0] wd,
                            input logic [63:0] wm, input logic [1:0] ty, input bit with_done);
    req_t  g;
    done_t d;
    g = '{ls: ls, idx: idx, wd: ls ? wd : 64'd0, wm: ls ? wm : 64'd0, ty: ty};
    exp_grant_q.push_back(g);
    if (with_done) begin
      d = '{ls: ls, data: rd(idx)};
      exp_done_q.push_back(d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_grant_q.size() != 0 || exp_done_q.size() != 0); i++)
      @(negedge clock);
    check_eq("drain_grants_left", 64'(exp_grant_q.size()), 64'd0);
    check_eq("drain_dones_left", 64'(exp_done_q.size()), 64'd0);
    #1;
  endtask

  // IF requester: hold valid until accepted, then present the next queued request
  initial begin
    req_t r;
    bit   acc = 1'b0;
    if_index_valid = 1'b0; if_index = '0; if_operation_type = '0;
    forever begin
      @(posedge clock); #1;
      if (acc) begin if_index_valid = 1'b0; acc = 1'b0; end
      if (!if_index_valid && if_q.size() != 0) begin
        r = if_q.pop_front();
        if_index_valid = 1'b1; if_index = r.idx; if_operation_type = r.ty;
      end
      @(negedge clock);
      if (if_index_valid && if_index_ready) acc = 1'b1;
    end
  end

  // LS requester
  initial begin
    req_t r;
    bit   acc = 1'b0;
    ls_index_valid = 1'b0; ls_index = '0; ls_write_data = '0; ls_write_mask = '0;
    ls_operation_type = '0;
    forever begin
      @(posedge clock); #1;
      if (acc) begin ls_index_valid = 1'b0; acc = 1'b0; end
      if (!ls_index_valid && ls_q.size() != 0) begin
        r = ls_q.pop_front();
        ls_index_valid = 1'b1; ls_index = r.idx; ls_write_data = r.wd;
        ls_write_mask = r.wm; ls_operation_type = r.ty;
      end
      @(negedge clock);
      if (ls_index_valid && ls_index_ready) acc = 1'b1;
    end
  end

  // Memory responder: ready after ready_delay cycles, done done_delay cycles after fire
  initial begin
    logic [63:0] idx;
    tbus_index_ready = 1'b0; tbus_operation_done = 1'b0; tbus_read_data = '0;
    @(posedge clock); #2;
    forever begin
      if (!resp_en) begin
        tbus_index_ready = man_ready; tbus_operation_done = man_done; tbus_read_data = man_data;
        @(posedge clock); #2;
      end else begin
        tbus_index_ready = 1'b0; tbus_operation_done = 1'b0;
        if (!tbus_index_valid) begin
          @(posedge clock); #2;
        end else begin
          repeat (ready_delay) begin @(posedge clock); #2; end
          idx = tbus_index;
          tbus_index_ready = 1'b1;
          if (done_delay == 0) begin
            tbus_operation_done = 1'b1; tbus_read_data = rd(idx);
          end
          @(posedge clock); #2;
          tbus_index_ready = 1'b0; tbus_operation_done = 1'b0;
          if (done_delay > 0) begin
            repeat (done_delay - 1) begin @(posedge clock); #2; end
            tbus_operation_done = 1'b1; tbus_read_data = rd(idx);
            @(posedge clock); #2;
            tbus_operation_done = 1'b0;
          end
        end
      end
    end
  end

  // Scoreboard monitor: checks each fire and each completion against the queues
  initial begin
    req_t  g;
    done_t d;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (tbus_index_valid && tbus_index_ready) begin
          if (exp_grant_q.size() == 0) check_eq("unexpected_grant", 64'd1, 64'd0);
          else begin
            g = exp_grant_q.pop_front();
            check_eq("grant_owner_ls", 64'(ls_index_ready), 64'(g.ls));
            check_eq("grant_ready_count", 64'(if_index_ready) + 64'(ls_index_ready), 64'd1);
            check_eq("grant_index", tbus_index, g.idx);
            check_eq("grant_wdata", tbus_write_data, g.wd);
            check_eq("grant_wmask", tbus_write_mask, g.wm);
            check_eq("grant_type", 64'(tbus_operation_type), 64'(g.ty));
          end
        end
        if (if_operation_done || ls_operation_done) begin
          if (if_operation_done) n_if_done++;
          if (ls_operation_done) n_ls_done++;
          if (exp_done_q.size() == 0) check_eq("unexpected_done", 64'd1, 64'd0);
          else begin
            d = exp_done_q.pop_front();
            check_eq("done_owner_ls", 64'(ls_operation_done), 64'(d.ls));
            check_eq("done_exclusive", 64'(if_operation_done) + 64'(ls_operation_done), 64'd1);
            check_eq("done_rdata", d.ls ? ls_read_data : if_read_data, d.data);
          end
        end
      end
    end
  end

  task automatic check_quiet(input string tag);
    check_eq({tag, "_tvalid"}, 64'(tbus_index_valid), 64'd0);
    check_eq({tag, "_if_ready"}, 64'(if_index_ready), 64'd0);
    check_eq({tag, "_ls_ready"}, 64'(ls_index_ready), 64'd0);
    check_eq({tag, "_if_done"}, 64'(if_operation_done), 64'd0);
    check_eq({tag, "_ls_done"}, 64'(ls_operation_done), 64'd0);
  endtask

  initial begin
    int  b_if, b_ls;
    bit  fired;
    reset_n = 1'b0;
    repeat (2) @(negedge clock); #1;
    check_quiet("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock); #1;

    // LS-only read, done three cycles after fire
    b_if = n_if_done; b_ls = n_ls_done;
    ready_delay = 0; done_delay = 3;
    req(1'b1, 64'h10, '0, '0, 2'd0);
    expect_txn(1'b1, 64'h10, '0, '0, 2'd0, 1'b1);
    drain();
    check_eq("ls_only_ls_dones", 64'(n_ls_done - b_ls), 64'd1);
    check_eq("ls_only_if_dones", 64'(n_if_done - b_if), 64'd0);

    // Contention in one IDLE cycle: LS first, then IF
    done_delay = 2;
    req(1'b0, 64'h80, '0, '0, 2'd0);
    req(1'b1, 64'h90, '0, '0, 2'd0);
    expect_txn(1'b1, 64'h90, '0, '0, 2'd0, 1'b1);
    expect_txn(1'b0, 64'h80, '0, '0, 2'd0, 1'b1);
    drain();

    // Starvation: four LS overtakes force IF; IF fire clears the counter so LS wins again
    done_delay = 1;
    req(1'b0, 64'h100, '0, '0, 2'd0);
    req(1'b0, 64'h101, '0, '0, 2'd0);
    for (int i = 0; i < 5; i++) req(1'b1, 64'h200 + 64'(i), '0, '0, 2'd0);
    for (int i = 0; i < 4; i++) expect_txn(1'b1, 64'h200 + 64'(i), '0, '0, 2'd0, 1'b1);
    expect_txn(1'b0, 64'h100, '0, '0, 2'd0, 1'b1);
    expect_txn(1'b1, 64'h204, '0, '0, 2'd0, 1'b1);
    expect_txn(1'b0, 64'h101, '0, '0, 2'd0, 1'b1);
    drain();

    // Backpressure on an LS store while IF waits
    ready_delay = 3; done_delay = 2;
    req(1'b1, 64'h20, 64'h1122_3344_5566_7788, 64'hFF00, 2'd1);
    req(1'b0, 64'h21, '0, '0, 2'd0);
    expect_txn(1'b1, 64'h20, 64'h1122_3344_5566_7788, 64'hFF00, 2'd1, 1'b1);
    expect_txn(1'b0, 64'h21, '0, '0, 2'd0, 1'b1);
    for (int i = 0; i < 10 && !tbus_index_valid; i++) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      check_eq("bp_index", tbus_index, 64'h20);
      check_eq("bp_wdata", tbus_write_data, 64'h1122_3344_5566_7788);
      check_eq("bp_wmask", tbus_write_mask, 64'hFF00);
      check_eq("bp_ls_ready", 64'(ls_index_ready), 64'd0);
      check_eq("bp_if_ready", 64'(if_index_ready), 64'd0);
      @(negedge clock);
    end
    drain();

    // Same-cycle fire and done
    ready_delay = 0; done_delay = 0;
    req(1'b0, 64'h30, '0, '0, 2'd0);
    req(1'b1, 64'h40, '0, '0, 2'd0);
    expect_txn(1'b1, 64'h40, '0, '0, 2'd0, 1'b1);
    expect_txn(1'b0, 64'h30, '0, '0, 2'd0, 1'b1);
    drain();

    // Spurious done while idle
    resp_en = 1'b0;
    @(posedge clock); #1;
    man_done = 1'b1; man_data = 64'hDEAD_BEEF;
    @(negedge clock); #1;
    check_quiet("spurious");
    @(posedge clock); #1;
    man_done = 1'b0;

    // Reset while waiting for done, late done ignored, then a normal IF transaction
    man_ready = 1'b1;
    req(1'b0, 64'h50, '0, '0, 2'd0);
    expect_txn(1'b0, 64'h50, '0, '0, 2'd0, 1'b0);
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) begin
      @(negedge clock);
      fired = if_index_valid && if_index_ready;
    end
    check_eq("rst_fire_seen", 64'(fired), 64'd1);
    @(posedge clock); #1;
    man_ready = 1'b0;
    #1 reset_n = 1'b0;
    @(negedge clock); #1;
    check_quiet("mid_reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    man_done = 1'b1; man_data = rd(64'h50);
    @(negedge clock); #1;
    check_quiet("late_done");
    @(posedge clock); #1;
    man_done = 1'b0;
    resp_en = 1'b1; done_delay = 2;
    req(1'b0, 64'h60, '0, '0, 2'd0);
    expect_txn(1'b0, 64'h60, '0, '0, 2'd0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
